yc_mem_req_master: RTL and testbench

//   Core-side NoC requester feeding yc_memmap-style endpoints.

---
 rtl/yc_noc_defs.sv | 76 +++++++
 rtl/yc_mem_req_master.sv | 149 ++++++++++++++
 tb/tb_yc_mem_req_master.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yc_noc_defs.sv
// Shared NoC definitions: flit layout, virtual channels, opcodes and
// helpers to build and pick apart flits.
package yc_noc_defs;

    localparam int unsigned XW   = 4;
    localparam int unsigned YW   = 4;
    localparam int unsigned OPW  = 4;
    localparam int unsigned LENW = 8;
    localparam int unsigned PAYW = 32;

    localparam logic VC_REQ  = 1'b0;
    localparam logic VC_RESP = 1'b1;

    localparam logic [OPW-1:0] OP_WRITE     = 4'h1;
    localparam logic [OPW-1:0] OP_READ_REQ  = 4'h2;
    localparam logic [OPW-1:0] OP_READ_RESP = 4'h3;

    // Payload carries {addr[15:0], data[15:0]}
    typedef struct packed {
        logic            vc;
        logic [OPW-1:0]  opc;
        logic [LENW-1:0] len;
        logic [XW-1:0]   src_x;
        logic [YW-1:0]   src_y;
        logic [XW-1:0]   dst_x;
        logic [YW-1:0]   dst_y;
        logic [PAYW-1:0] pay;
    } flit_t;

    function automatic flit_t build_flit(
        input logic            vc,
        input logic [OPW-1:0]  opc,
        input logic [LENW-1:0] len,
        input logic [XW-1:0]   src_x,
        input logic [YW-1:0]   src_y,
        input logic [XW-1:0]   dst_x,
        input logic [YW-1:0]   dst_y,
        input logic [PAYW-1:0] pay
    );
        flit_t f;
        f.vc    = vc;
        f.opc   = opc;
        f.len   = len;
        f.src_x = src_x;
        f.src_y = src_y;
        f.dst_x = dst_x;
        f.dst_y = dst_y;
        f.pay   = pay;
        return f;
    endfunction

    function automatic logic [OPW-1:0] get_opc(input flit_t f);
        return f.opc;
    endfunction

    function automatic logic [PAYW-1:0] get_pay(input flit_t f);
        return f.pay;
    endfunction

    function automatic logic [XW-1:0] get_src_x(input flit_t f);
        return f.src_x;
    endfunction

    function automatic logic [YW-1:0] get_src_y(input flit_t f);
        return f.src_y;
    endfunction

    function automatic logic [XW-1:0] get_dst_x(input flit_t f);
        return f.dst_x;
    endfunction

    function automatic logic [YW-1:0] get_dst_y(input flit_t f);
        return f.dst_y;
    endfunction

endpackage

// File: rtl/yc_mem_req_master.sv
// Core-side NoC requester: turns a load/store port into OP_WRITE /
// OP_READ_REQ flits and returns OP_READ_RESP data to the core.
// Writes are posted, one read is outstanding at a time, reads time out.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/ready/we/addr/wdata   core request port
//   resp_valid/rdata/err            read completion (1-cycle pulse)
//   tx_valid/tx_flit/tx_ready       request flit output
//   rx_valid/rx_flit/rx_ready       response flit input (always sinks)
//   drop_cnt                        saturating count of discarded rx flits
module yc_mem_req_master
    import yc_noc_defs::*;
#(
    parameter int unsigned X_ID    = 0,
    parameter int unsigned Y_ID    = 0,
    parameter int unsigned DST_X   = 1,
    parameter int unsigned DST_Y   = 0,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        tx_valid,
    output flit_t       tx_flit,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  flit_t       rx_flit,
    output logic        rx_ready,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_t;

    state_t        st_q;
    logic [TW-1:0] timer_q;
    logic [15:0]   addr_q;
    logic          we_q;
    logic          tx_valid_q;
    flit_t         tx_flit_q;
    logic          resp_valid_q;
    logic [15:0]   resp_rdata_q;
    logic          resp_err_q;
    logic [7:0]    drop_cnt_q;

    logic match_c;
    logic timeout_c;
    logic drop_c;
    logic unused_rx_c;

    // Response for the outstanding read: right opcode, routed to us, from the target, same address
    assign match_c = rx_valid && (st_q == WAIT_RESP)
                  && (get_opc(rx_flit) == OP_READ_RESP)
                  && (get_dst_x(rx_flit) == XW'(X_ID)) && (get_dst_y(rx_flit) == YW'(Y_ID))
                  && (get_src_x(rx_flit) == XW'(DST_X)) && (get_src_y(rx_flit) == YW'(DST_Y))
                  && (get_pay(rx_flit)[31:16] == addr_q);

    assign timeout_c = (st_q == WAIT_RESP) && (timer_q == TW'(TIMEOUT - 1));

    // Every received flit that does not complete the pending read is discarded
    assign drop_c = rx_valid && !match_c;

    // vc and len are not needed to recognise a response
    assign unused_rx_c = ^{rx_flit.vc, rx_flit.len};

    assign req_ready  = (st_q == IDLE);
    assign rx_ready   = 1'b1;
    assign tx_valid   = tx_valid_q;
    assign tx_flit    = tx_flit_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign drop_cnt   = drop_cnt_q;

    // Request FSM, read timer and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= IDLE;
            timer_q      <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_flit_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            resp_valid_q <= 1'b0;

            if (drop_c && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end

            case (st_q)
                IDLE: begin
                    if (req_valid) begin
                        tx_flit_q  <= build_flit(VC_REQ,
                                                 req_we ? OP_WRITE : OP_READ_REQ,
                                                 8'd1,
                                                 XW'(X_ID), YW'(Y_ID),
                                                 XW'(DST_X), YW'(DST_Y),
                                                 {req_addr, req_we ? req_wdata : 16'h0000});
                        addr_q     <= req_addr;
                        we_q       <= req_we;
                        tx_valid_q <= 1'b1;
                        st_q       <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (we_q) begin
                            st_q <= IDLE;
                        end else begin
                            st_q    <= WAIT_RESP;
                            timer_q <= '0;
                        end
                    end
                end
                WAIT_RESP: begin
                    timer_q <= timer_q + TW'(1);
                    // A response landing on the timeout cycle still completes the read
                    if (match_c) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= get_pay(rx_flit)[15:0];
                        resp_err_q   <= 1'b0;
                        st_q         <= IDLE;
                    end else if (timeout_c) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= 16'h0000;
                        resp_err_q   <= 1'b1;
                        st_q         <= IDLE;
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_yc_mem_req_master.sv
// Bench for yc_mem_req_master: a behavioural memory-mapped endpoint
// (RESP_DELAY=2) answers requests; directed and random traffic is checked
// against a memory model kept in the bench.
module tb_yc_mem_req_master;
    import yc_noc_defs::*;

    localparam int unsigned TIMEOUT    = 8;
    localparam int unsigned RESP_DELAY = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        tx_valid;
    flit_t       tx_flit;
    logic        tx_ready;
    logic        rx_valid;
    flit_t       rx_flit;
    logic        rx_ready;
    logic [7:0]  drop_cnt;

    yc_mem_req_master #(
        .X_ID(0), .Y_ID(0), .DST_X(1), .DST_Y(0), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .tx_valid(tx_valid), .tx_flit(tx_flit), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_flit(rx_flit), .rx_ready(rx_ready),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- endpoint (environment) ----------------
    logic        ep_mute = 1'b0;
    logic [15:0] ep_mem [logic [15:0]];
    int          ep_wr_cnt = 0;
    int          ep_rd_cnt = 0;
    int          last_hs_cyc = 0;
    flit_t       inj_q [$];
    int          inj_rd = 0;

    function automatic flit_t mk_resp(input logic [15:0] a, input logic [15:0] d);
        flit_t f;
        f       = '0;
        f.vc    = VC_RESP;
        f.opc   = OP_READ_RESP;
        f.len   = 8'd1;
        f.src_x = 4'd1;
        f.src_y = 4'd0;
        f.dst_x = 4'd0;
        f.dst_y = 4'd0;
        f.pay   = {a, d};
        return f;
    endfunction

    function automatic logic [15:0] ep_read(input logic [15:0] a);
        if (a == 16'hF000) return 16'h434B;
        if (a == 16'hF002) return 16'h524F;
        if (a[15:12] == 4'h0) return ep_mem.exists(a) ? ep_mem[a] : 16'h0000;
        return 16'hDEAD;
    endfunction

    initial begin
        int    pend;
        flit_t pend_flit;
        pend      = 0;
        pend_flit = '0;
        rx_valid  = 1'b0;
        rx_flit   = '0;
        forever begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rx_valid = 1'b1;
                    rx_flit  = pend_flit;
                end
            end
            if (!rx_valid && (inj_rd < inj_q.size())) begin
                rx_valid = 1'b1;
                rx_flit  = inj_q[inj_rd];
                inj_rd++;
            end
            // handshake completes at the coming posedge
            if (tx_valid && tx_ready && rst_n) begin
                last_hs_cyc = cyc;
                if (tx_flit.opc == OP_WRITE) begin
                    if (tx_flit.pay[31:28] == 4'h0) ep_mem[tx_flit.pay[31:16]] = tx_flit.pay[15:0];
                    ep_wr_cnt++;
                end else if (tx_flit.opc == OP_READ_REQ) begin
                    ep_rd_cnt++;
                    if (!ep_mute) begin
                        pend      = RESP_DELAY;
                        pend_flit = mk_resp(tx_flit.pay[31:16], ep_read(tx_flit.pay[31:16]));
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] model_mem [logic [15:0]];
    int          exp_drop = 0;

    function automatic logic [15:0] exp_read(input logic [15:0] a);
        case (a)
            16'hF000: return 16'h434B;
            16'hF002: return 16'h524F;
            default: begin
                if (a < 16'h1000) return model_mem.exists(a) ? model_mem[a] : 16'h0000;
                return 16'hDEAD;
            end
        endcase
    endfunction

    function automatic flit_t exp_req(input logic we, input logic [15:0] a, input logic [15:0] d);
        flit_t f;
        f.vc    = 1'b0;
        f.opc   = we ? 4'h1 : 4'h2;
        f.len   = 8'd1;
        f.src_x = 4'd0;
        f.src_y = 4'd0;
        f.dst_x = 4'd1;
        f.dst_y = 4'd0;
        f.pay   = {a, we ? d : 16'h0000};
        return f;
    endfunction

    // ---------------- stimulus tasks (called at a negedge) ----------------
    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d, input int stall);
        int    n;
        flit_t ef;
        n  = 0;
        ef = exp_req(we, a, d);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_wait", 64'(req_ready), 64'd1);
        tx_ready  = (stall == 0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        check_eq("tx_valid", 64'(tx_valid), 64'd1);
        check_eq("tx_flit", 64'(tx_flit), 64'(ef));
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check_eq("stall_tx_valid", 64'(tx_valid), 64'd1);
                check_eq("stall_tx_flit", 64'(tx_flit), 64'(ef));
                check_eq("stall_req_ready", 64'(req_ready), 64'd0);
            end
            @(posedge clk);
            #1 tx_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int stall);
        int w0;
        int n;
        w0 = ep_wr_cnt;
        issue(1'b1, a, d, stall);
        if (a < 16'h1000) model_mem[a] = d;
        n = 0;
        while (ep_wr_cnt == w0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        check_eq("write_delivered_once", 64'(ep_wr_cnt - w0), 64'd1);
        check_eq("tx_idle_after_write", 64'(tx_valid), 64'd0);
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!resp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("resp_seen", 64'(resp_valid), 64'd1);
    endtask

    task automatic do_read(input logic [15:0] a, input int stall);
        logic [15:0] ed;
        ed = exp_read(a);
        issue(1'b0, a, 16'h0000, stall);
        wait_resp();
        check_eq("rdata", 64'(resp_rdata), 64'(ed));
        check_eq("rerr", 64'(resp_err), 64'd0);
        @(negedge clk);
        check_eq("resp_pulse_end", 64'(resp_valid), 64'd0);
        check_eq("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    endtask

    // queue a flit for the endpoint to present on rx; returns one cycle after it was consumed
    task automatic inject(input flit_t f);
        @(posedge clk);
        #1 inj_q.push_back(f);
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] a;
        logic [15:0] d;
        int          r;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        tx_ready  = 1'b1;
        #2;
        check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
        check_eq("rst_tx_flit", 64'(tx_flit), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check_eq("rst_resp_err", 64'(resp_err), 64'd0);
        check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rx_ready", 64'(rx_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // write then read back
        do_write(16'h0010, 16'hBEEF, 0);
        do_read(16'h0010, 0);

        // fixed and unmapped regions
        do_read(16'hF000, 0);
        do_read(16'hF002, 0);
        do_read(16'hA000, 0);

        // backpressure on a write
        do_write(16'h0012, 16'h1234, 5);
        do_read(16'h0012, 0);

        // silent endpoint: timeout exactly TIMEOUT cycles after the handshake
        ep_mute = 1'b1;
        issue(1'b0, 16'h0030, 16'h0000, 0);
        wait_resp();
        check_eq("to_err", 64'(resp_err), 64'd1);
        check_eq("to_rdata", 64'(resp_rdata), 64'd0);
        check_eq("to_latency", 64'(cyc - (last_hs_cyc + 1)), 64'(TIMEOUT));
        @(negedge clk);
        check_eq("to_pulse_end", 64'(resp_valid), 64'd0);
        inject(mk_resp(16'h0030, 16'h5555));
        exp_drop++;
        check_eq("late_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        check_eq("late_no_resp", 64'(resp_valid), 64'd0);

        // wrong-address response is dropped, correct one still completes
        issue(1'b0, 16'h0010, 16'h0000, 0);
        inject(mk_resp(16'h0020, 16'h7777));
        exp_drop++;
        check_eq("addr_mm_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        check_eq("addr_mm_no_resp", 64'(resp_valid), 64'd0);
        inject(mk_resp(16'h0010, exp_read(16'h0010)));
        check_eq("addr_ok_resp", 64'(resp_valid), 64'd1);
        check_eq("addr_ok_rdata", 64'(resp_rdata), 64'(exp_read(16'h0010)));
        check_eq("addr_ok_err", 64'(resp_err), 64'd0);
        check_eq("addr_ok_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        @(negedge clk);

        // reset while waiting for a response
        issue(1'b0, 16'h0040, 16'h0000, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #2;
        exp_drop = 0;
        check_eq("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        check_eq("mid_rst_tx_flit", 64'(tx_flit), 64'd0);
        check_eq("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("mid_rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check_eq("mid_rst_resp_err", 64'(resp_err), 64'd0);
        check_eq("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check_eq("mid_rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        ep_mute = 1'b0;
        @(negedge clk);
        do_read(16'h0010, 0);

        // random traffic
        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0:       a = 16'(2 * $urandom_range(0, 15));
                1:       a = 16'hF000;
                2:       a = 16'hF002;
                default: a = 16'hA000 + 16'(2 * $urandom_range(0, 255));
            endcase
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, d, int'($urandom_range(0, 2)));
            else                           do_read(a, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
